// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the pipeline MEM
// stage (P) and an external loader/debug master (X). Every access occupies a
// fixed MEM_LAT-cycle busy window followed by a one-cycle DONE bubble.
// X is forced through after STARVE_MAX consecutive P grants taken while X waits.
// Optional: define DMEM_ARB_PERF_EN to add the perf_stall_cnt/perf_x_grants
// counters and their ports.
module dmem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p_req,
  input  logic              p_we,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [DATA_W-1:0] p_wdata,
  output logic [DATA_W-1:0] p_rdata,
  output logic              p_stall,
  input  logic              x_req,
  input  logic              x_we,
  input  logic [ADDR_W-1:0] x_addr,
  input  logic [DATA_W-1:0] x_wdata,
  output logic              x_gnt,
  output logic              x_done,
  output logic [DATA_W-1:0] x_rdata,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic              m_write_en,
  output logic              m_read_en,
  input  logic [DATA_W-1:0] m_rdata
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [15:0]       perf_x_grants
`endif
);

  typedef enum logic [2:0] {IDLE, BUSY_P, BUSY_X, DONE_P, DONE_X} state_t;

  localparam logic [2:0] LAT_M1     = 3'(MEM_LAT - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t     r_state, w_next;
  logic [2:0] r_cnt;
  logic [3:0] r_starve;
  logic       r_we;
  logic       w_x_win, w_grant, w_busy, w_first, w_last;

  // X wins when P is quiet, or when P has starved it for STARVE_MAX grants
  assign w_x_win = x_req && (!p_req || (r_starve == STARVE_LIM));
  assign w_grant = (r_state == IDLE) && (x_req || p_req);
  assign w_busy  = (r_state == BUSY_P) || (r_state == BUSY_X);
  // busy counter runs MEM_LAT-1 down to 0: top value = first cycle, 0 = last
  assign w_first = w_busy && (r_cnt == LAT_M1);
  assign w_last  = w_busy && (r_cnt == 3'd0);

  // state register; reset drops every strobe immediately since they decode state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // next-state and combinational handshake/strobe outputs
  always_comb begin
    w_next     = r_state;
    x_gnt      = 1'b0;
    x_done     = 1'b0;
    m_read_en  = 1'b0;
    m_write_en = 1'b0;
    p_stall    = p_req && (r_state != DONE_P);
    case (r_state)
      IDLE: begin
        if (w_x_win) begin
          x_gnt  = 1'b1;
          w_next = BUSY_X;
        end else if (p_req) begin
          w_next = BUSY_P;
        end
      end
      BUSY_P, BUSY_X: begin
        m_read_en  = !r_we;
        m_write_en = r_we && w_first;
        if (w_last) w_next = (r_state == BUSY_P) ? DONE_P : DONE_X;
      end
      DONE_P: w_next = IDLE;
      DONE_X: begin
        x_done = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // request fields latched at grant only; read data captured on the last busy cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_we    <= 1'b0;
      r_cnt   <= 3'd0;
      m_addr  <= '0;
      m_wdata <= '0;
      p_rdata <= '0;
      x_rdata <= '0;
    end else begin
      if (w_grant) begin
        r_we    <= w_x_win ? x_we    : p_we;
        m_addr  <= w_x_win ? x_addr  : p_addr;
        m_wdata <= w_x_win ? x_wdata : p_wdata;
        r_cnt   <= LAT_M1;
      end else if (w_busy && (r_cnt != 3'd0)) begin
        r_cnt <= r_cnt - 3'd1;
      end
      if (w_last && !r_we) begin
        if (r_state == BUSY_P) p_rdata <= m_rdata;
        else                   x_rdata <= m_rdata;
      end
    end
  end

  // starvation counter: P grants taken while X waits; cleared by X grant or X idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_starve <= 4'd0;
    end else if (r_state == IDLE) begin
      if (!x_req || w_x_win)
        r_starve <= 4'd0;
      else if (p_req && (r_starve != 4'hF))
        r_starve <= r_starve + 4'd1;
    end
  end

`ifdef DMEM_ARB_PERF_EN
  // saturating performance counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_stall_cnt <= '0;
      perf_x_grants  <= '0;
    end else begin
      if (p_stall && (perf_stall_cnt != '1)) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (x_gnt && (perf_x_grants != '1))    perf_x_grants  <= perf_x_grants + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed timing scenarios on a MEM_LAT=2 and a
// MEM_LAT=1 instance, then randomized P/X traffic against a transaction-level
// memory model with a queue-based scoreboard.
module tb_dmem_arbiter;
  localparam int A_LAT = 2;
  localparam int A_STV = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // instance A (MEM_LAT=2)
  logic        a_p_req, a_p_we, a_p_stall, a_x_req, a_x_we, a_x_gnt, a_x_done;
  logic [31:0] a_p_addr, a_p_wdata, a_p_rdata, a_x_addr, a_x_wdata, a_x_rdata;
  logic [31:0] a_m_addr, a_m_wdata, a_m_rdata;
  logic        a_m_write_en, a_m_read_en;
  // instance B (MEM_LAT=1)
  logic        b_p_req, b_p_we, b_p_stall, b_x_req, b_x_we, b_x_gnt, b_x_done;
  logic [31:0] b_p_addr, b_p_wdata, b_p_rdata, b_x_addr, b_x_wdata, b_x_rdata;
  logic [31:0] b_m_addr, b_m_wdata, b_m_rdata;
  logic        b_m_write_en, b_m_read_en;
`ifdef DMEM_ARB_PERF_EN
  logic [31:0] a_perf_stall, b_perf_stall;
  logic [15:0] a_perf_xg, b_perf_xg;
`endif

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(A_LAT), .STARVE_MAX(A_STV)) u_a (
    .clk(clk), .reset(reset),
    .p_req(a_p_req), .p_we(a_p_we), .p_addr(a_p_addr), .p_wdata(a_p_wdata),
    .p_rdata(a_p_rdata), .p_stall(a_p_stall),
    .x_req(a_x_req), .x_we(a_x_we), .x_addr(a_x_addr), .x_wdata(a_x_wdata),
    .x_gnt(a_x_gnt), .x_done(a_x_done), .x_rdata(a_x_rdata),
    .m_addr(a_m_addr), .m_wdata(a_m_wdata), .m_write_en(a_m_write_en),
    .m_read_en(a_m_read_en), .m_rdata(a_m_rdata)
`ifdef DMEM_ARB_PERF_EN
    , .perf_stall_cnt(a_perf_stall), .perf_x_grants(a_perf_xg)
`endif
  );

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(A_STV)) u_b (
    .clk(clk), .reset(reset),
    .p_req(b_p_req), .p_we(b_p_we), .p_addr(b_p_addr), .p_wdata(b_p_wdata),
    .p_rdata(b_p_rdata), .p_stall(b_p_stall),
    .x_req(b_x_req), .x_we(b_x_we), .x_addr(b_x_addr), .x_wdata(b_x_wdata),
    .x_gnt(b_x_gnt), .x_done(b_x_done), .x_rdata(b_x_rdata),
    .m_addr(b_m_addr), .m_wdata(b_m_wdata), .m_write_en(b_m_write_en),
    .m_read_en(b_m_read_en), .m_rdata(b_m_rdata)
`ifdef DMEM_ARB_PERF_EN
    , .perf_stall_cnt(b_perf_stall), .perf_x_grants(b_perf_xg)
`endif
  );

  function automatic logic [31:0] init_word(int i);
    if (i == 4)  return 32'hDEADBEEF;
    if (i == 12) return 32'hC0FFEE00;
    return (32'(i) * 32'h01010101) ^ 32'h5A5A0000;
  endfunction

  // memory behind instance A: word-indexed, re-initialised by reset
  logic [31:0] mem [256];
  always @(posedge clk or posedge reset) begin
    if (reset) for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
    else if (a_m_write_en) mem[a_m_addr[9:2]] <= a_m_wdata;
  end
  assign a_m_rdata = mem[a_m_addr[9:2]];
  // instance B memory is a fixed function of the address
  assign b_m_rdata = b_m_addr ^ 32'hA5A50000;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // scoreboard
  typedef struct { logic we; logic [31:0] data; int t; } exp_t;
  exp_t        p_q[$];
  exp_t        x_q[$];
  logic [31:0] ref_mem [256];
  logic        sb_en = 1'b0;
  int          last_gnt = 0;

  always @(negedge clk) begin
    if (sb_en) begin
      exp_t e;
      int   lat;
      #2;
      if (a_x_gnt) last_gnt = cyc;
      if (a_x_done) begin
        if (x_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL x_unexpected_done: got done with empty queue at cycle %0d", cyc);
        end else begin
          e = x_q.pop_front();
          if (!e.we) chk("x_rdata", a_x_rdata, e.data);
          chk("x_gnt_to_done", 32'(cyc - last_gnt), 32'(A_LAT + 1));
        end
      end
      if (a_p_req && !a_p_stall) begin
        if (p_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL p_unexpected_done: got completion with empty queue at cycle %0d", cyc);
        end else begin
          e   = p_q.pop_front();
          lat = cyc - e.t + 1;
          if (!e.we) chk("p_rdata", a_p_rdata, e.data);
          n_tests++;
          if (lat < A_LAT + 2 || lat > 2 * (A_LAT + 2)) begin
            n_fail++;
            $display("FAIL p_latency: got %0d cycles, required %0d..%0d", lat, A_LAT + 2, 2 * (A_LAT + 2));
          end
        end
      end
    end
  end

  task automatic p_drv();
    for (int n = 0; n < 60; n++) begin
      int          k;
      int          idx;
      logic        we;
      logic [31:0] wd, ex;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      @(negedge clk);
      idx = 64 + int'($urandom_range(0, 15));
      we  = 1'($urandom_range(0, 1));
      wd  = $urandom;
      ex  = we ? 32'h0 : ref_mem[idx];
      if (we) ref_mem[idx] = wd;
      a_p_req = 1'b1; a_p_we = we; a_p_addr = 32'(idx) << 2; a_p_wdata = wd;
      p_q.push_back('{we, ex, cyc});
      #1;
      k = 0;
      while (a_p_stall && k < 20) begin
        @(negedge clk); #1; k++;
      end
      if (k >= 20) chk("p_timeout", 32'(k), 32'd0);
      @(negedge clk);
      a_p_req = 1'b0; a_p_addr = $urandom; a_p_wdata = $urandom;
    end
  endtask

  task automatic x_drv();
    for (int n = 0; n < 40; n++) begin
      int          k;
      int          idx;
      logic        we;
      logic [31:0] wd, ex;
      repeat ($urandom_range(0, 5)) @(negedge clk);
      @(negedge clk);
      idx = 96 + int'($urandom_range(0, 15));
      we  = 1'($urandom_range(0, 1));
      wd  = $urandom;
      ex  = we ? 32'h0 : ref_mem[idx];
      if (we) ref_mem[idx] = wd;
      a_x_req = 1'b1; a_x_we = we; a_x_addr = 32'(idx) << 2; a_x_wdata = wd;
      x_q.push_back('{we, ex, cyc});
      #1;
      k = 0;
      while (!a_x_gnt && k < 60) begin
        @(negedge clk); #1; k++;
      end
      if (k >= 60) chk("x_gnt_timeout", 32'(k), 32'd0);
      // scramble fields after grant: the latched access must not notice
      @(negedge clk);
      a_x_req = 1'b0; a_x_we = 1'($urandom); a_x_addr = $urandom; a_x_wdata = $urandom;
    end
  endtask

  initial begin #400000; $display("FAIL watchdog: simulation did not finish"); $fatal(1); end

  initial begin
    logic        seq [$];
    logic        prev_re;
    logic        exp_x;
    int          st, nd;

    reset = 1'b1;
    a_p_req = 0; a_p_we = 0; a_p_addr = 0; a_p_wdata = 0;
    a_x_req = 0; a_x_we = 0; a_x_addr = 0; a_x_wdata = 0;
    b_p_req = 0; b_p_we = 0; b_p_addr = 0; b_p_wdata = 0;
    b_x_req = 0; b_x_we = 0; b_x_addr = 0; b_x_wdata = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_strobes", 32'({a_p_stall, a_x_gnt, a_x_done, a_m_write_en, a_m_read_en}), 32'd0);
    chk("rst_m_addr", a_m_addr, 32'd0);
    chk("rst_m_wdata", a_m_wdata, 32'd0);
    chk("rst_p_rdata", a_p_rdata, 32'd0);
    chk("rst_x_rdata", a_x_rdata, 32'd0);
    @(negedge clk); reset = 1'b0;

    // P read at 0x10, four-cycle access
    @(negedge clk); a_p_req = 1; a_p_we = 0; a_p_addr = 32'h10;
    #1 chk("t1_stall_c0", 32'(a_p_stall), 32'd1);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk); #1;
      chk($sformatf("t1_stall_c%0d", c), 32'(a_p_stall), 32'(c < 3));
      chk($sformatf("t1_rden_c%0d", c), 32'(a_m_read_en), 32'(c < 3));
      if (c == 3) chk("t1_p_rdata", a_p_rdata, 32'hDEADBEEF);
    end
    @(negedge clk); a_p_req = 0;

    // X write 0x55 to 0x20
    @(negedge clk); a_x_req = 1; a_x_we = 1; a_x_addr = 32'h20; a_x_wdata = 32'h55;
    #1 chk("t2_gnt", 32'(a_x_gnt), 32'd1);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) a_x_req = 0;
      #1;
      chk($sformatf("t2_wren_c%0d", c), 32'(a_m_write_en), 32'(c == 1));
      chk($sformatf("t2_done_c%0d", c), 32'(a_x_done), 32'(c == 3));
      if (c == 1) begin
        chk("t2_m_addr", a_m_addr, 32'h20);
        chk("t2_m_wdata", a_m_wdata, 32'h55);
      end
    end
    chk("t2_mem", mem[8], 32'h55);

    // both requesting continuously: starvation forcing
    @(negedge clk);
    a_p_req = 1; a_p_we = 0; a_p_addr = 32'h40;
    a_x_req = 1; a_x_we = 0; a_x_addr = 32'h80;
    prev_re = 1'b0;
    for (int c = 0; c < 80 && seq.size() < 10; c++) begin
      @(negedge clk); #1;
      if (a_m_read_en && !prev_re) seq.push_back(a_m_addr == 32'h80);
      prev_re = a_m_read_en;
    end
    a_p_req = 0; a_x_req = 0;
    chk("t3_grant_count", 32'(seq.size()), 32'd10);
    st = 0;
    for (int k = 0; k < 10 && k < seq.size(); k++) begin
      exp_x = (st == A_STV);
      st    = exp_x ? 0 : st + 1;
      chk($sformatf("t3_grant%0d_is_x", k), 32'(seq[k]), 32'(exp_x));
    end
    repeat (6) @(negedge clk);

    // P arrives the cycle after an X read grant
    @(negedge clk); a_x_req = 1; a_x_we = 0; a_x_addr = 32'h30;
    #1 chk("t4_gnt", 32'(a_x_gnt), 32'd1);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) begin a_x_req = 0; a_p_req = 1; a_p_we = 0; a_p_addr = 32'h14; end
      if (c == 8) a_p_req = 0;
      #1;
      if (c <= 7) chk($sformatf("t4_stall_c%0d", c), 32'(a_p_stall), 32'(c < 7));
      chk($sformatf("t4_done_c%0d", c), 32'(a_x_done), 32'(c == 3));
      if (c == 3) chk("t4_x_rdata", a_x_rdata, 32'hC0FFEE00);
      if (c == 7) chk("t4_p_rdata", a_p_rdata, init_word(5));
    end

    // reset during the first busy cycle of an X write
    @(negedge clk); a_x_req = 1; a_x_we = 1; a_x_addr = 32'h24; a_x_wdata = 32'h77;
    #1 chk("t5_gnt", 32'(a_x_gnt), 32'd1);
    @(negedge clk); a_x_req = 0;
    #1 chk("t5_wren_before", 32'(a_m_write_en), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("t5_strobes_after", 32'({a_m_write_en, a_m_read_en, a_x_done, a_x_gnt}), 32'd0);
    chk("t5_m_addr", a_m_addr, 32'd0);
    chk("t5_m_wdata", a_m_wdata, 32'd0);
    chk("t5_p_rdata", a_p_rdata, 32'd0);
    @(negedge clk); reset = 1'b0;
    nd = 0;
    repeat (5) begin @(negedge clk); #1; if (a_x_done) nd++; end
    chk("t5_no_done", 32'(nd), 32'd0);
    chk("t5_mem_untouched", mem[9], init_word(9));

    // MEM_LAT=1 back-to-back reads at 0x0 then 0x4
    @(negedge clk); b_p_req = 1; b_p_we = 0; b_p_addr = 32'h0;
    #1 chk("t6_stall_c0", 32'(b_p_stall), 32'd1);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 3) b_p_addr = 32'h4;
      if (c == 6) b_p_req = 0;
      #1;
      if (c <= 5) chk($sformatf("t6_stall_c%0d", c), 32'(b_p_stall), 32'(c != 2 && c != 5));
      chk($sformatf("t6_rden_c%0d", c), 32'(b_m_read_en), 32'(c == 1 || c == 4));
      if (c == 2) chk("t6_rdata0", b_p_rdata, 32'hA5A50000);
      if (c == 5) chk("t6_rdata1", b_p_rdata, 32'hA5A50004);
    end

    // randomized traffic on disjoint P/X regions
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    @(negedge clk);
    sb_en = 1'b1;
    fork
      p_drv();
      x_drv();
    join
    repeat (12) @(negedge clk);
    sb_en = 1'b0;
    chk("p_q_empty", 32'(p_q.size()), 32'd0);
    chk("x_q_empty", 32'(x_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: the pipeline MEM stage (port P) and an external loader/debug master (port X).
- Sequences every memory access through a fixed-latency busy window and returns read data.
- Drives a stall to freeze the pipeline while its access is pending.
- Sits between the EX/MEM pipeline registers and data_memory.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 2, busy cycles per access (legal 1..7)
- STARVE_MAX, 4, consecutive P grants, taken while X waits, before X is forced through (legal 1..15)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- p_req  in  1  pipeline access request (mem_read | mem_write)
- p_we  in  1  pipeline write (1) / read (0)
- p_addr  in  ADDR_W  pipeline address
- p_wdata  in  DATA_W  pipeline write data
- p_rdata  out  DATA_W  pipeline read data, valid while p_stall=0 after completion
- p_stall  out  1  freeze IF/ID/EX/MEM registers
- x_req  in  1  external request; held with its fields until x_gnt
- x_we  in  1  external write/read
- x_addr  in  ADDR_W  external address
- x_wdata  in  DATA_W  external write data
- x_gnt  out  1  1-cycle acceptance pulse
- x_done  out  1  1-cycle completion pulse
- x_rdata  out  DATA_W  external read data, valid with x_done
- m_addr  out  ADDR_W  memory address
- m_wdata  out  DATA_W  memory write data
- m_write_en  out  1  memory write strobe
- m_read_en  out  1  memory read enable
- m_rdata  in  DATA_W  memory read data

Behaviour:
- Clock and reset: single clock, clk. reset is asynchronous and active-high.
- Reset values: FSM=IDLE, starve_cnt=0, busy counter=0. All outputs 0, including p_rdata and x_rdata.
- FSM states: IDLE, BUSY_P, BUSY_X, DONE_P, DONE_X.
- IDLE, winner selection:
  - X wins if x_req && (!p_req || starve_cnt==STARVE_MAX).
  - Otherwise P wins if p_req.
  - No request: stay in IDLE.
- On a grant:
  - Latch we/addr/wdata into the m_* registers and load the busy counter with MEM_LAT-1.
  - Go to BUSY_P or BUSY_X.
  - x_gnt=1 combinationally in the IDLE cycle where X wins.
- starve_cnt:
  - Increments (saturating) on each P grant while x_req=1.
  - Clears on an X grant, or on any IDLE cycle with x_req=0.
- BUSY_*:
  - Lasts exactly MEM_LAT cycles.
  - m_read_en=1 on every busy cycle of a read.
  - m_write_en=1 on the first busy cycle of a write only.
  - On the last busy cycle of a read, m_rdata is registered into p_rdata (BUSY_P) or x_rdata (BUSY_X).
  - Then go to the matching DONE_* state.
- DONE_*:
  - One cycle; no grant is issued. Next state is IDLE.
  - DONE_X: x_done=1.
  - DONE_P: p_stall is released.
- p_stall = p_req && !(state==DONE_P), combinational.
  - Pipeline access latency is MEM_LAT+2 cycles, request cycle included.
  - Stall is high for MEM_LAT+1 of those cycles.
- Request fields are sampled only at grant. Changes during BUSY are ignored.
- m_addr/m_wdata hold their last values in IDLE/DONE. m_write_en and m_read_en are 0 there.
- P requests arriving during BUSY_X/DONE_X stall until P is granted and completes.
- Reset mid-access:
  - FSM goes to IDLE immediately and all strobes drop asynchronously.
  - The pending x_done or stall release never occurs.

Optional Feature:
- Macro: DMEM_ARB_PERF_EN.
- Defined: adds output ports perf_stall_cnt (32) and perf_x_grants (16).
  - perf_stall_cnt counts cycles with p_stall=1.
  - perf_x_grants counts x_gnt pulses.
  - Both saturate at all-ones and reset to 0.
- Undefined: neither the ports nor the counters exist. All other behaviour is identical.

Test Plan:
- MEM_LAT=2, P read at 0x10, m_rdata=0xDEADBEEF -> p_stall=1 in cycles 0-2, 0 in cycle 3; m_read_en=1 in cycles 1-2; p_rdata=0xDEADBEEF in cycle 3.
- X write, addr 0x20, data 0x55, P idle -> x_gnt in cycle 0; m_write_en=1 in cycle 1 only with m_addr=0x20, m_wdata=0x55; x_done in cycle 3.
- p_req and x_req held high continuously, STARVE_MAX=4 -> grant sequence P,P,P,P,X,P,P,P,P,X; starve_cnt back to 0 after each X.
- p_req raised in the cycle after x_gnt -> p_stall stays 1 through BUSY_X and DONE_X; P granted in the next IDLE; stall released in DONE_P (cycle 7 with MEM_LAT=2).
- reset pulsed during the first busy cycle of an X write -> m_write_en=0 immediately; state IDLE; x_done never pulses; outputs read 0.
- MEM_LAT=1, back-to-back P reads at 0x0 then 0x4 -> each completes in 3 cycles; one DONE bubble between them; second read's data appears at cycle 5.
